// File: rtl/ysyx_220053_csr_ctrl.sv
// SYSTEM-instruction controller: decodes CSR ops, ecall and mret, strobes the
// CSR file for one EXEC cycle and holds a writeback/redirect response until taken.
module ysyx_220053_csr_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [63:0] pc,
  input  logic [63:0] rs1_data,
  output logic        Csrwen,
  output logic        Ecall,
  output logic        Mret,
  output logic [2:0]  CsrOp,
  output logic [11:0] CsrId,
  output logic [63:0] datain,
  output logic [63:0] epc_in,
  input  logic [63:0] csrres,
  input  logic [63:0] mtvec_o,
  input  logic [63:0] mepc_o,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        rd_wen,
  output logic [4:0]  rd_addr,
  output logic [63:0] rd_data,
  output logic        redirect,
  output logic [63:0] redirect_pc,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_inst;
  logic [63:0] r_pc;
  logic [63:0] r_rs1;
  logic [63:0] r_rd_data;
  logic [63:0] r_redirect_pc;

  logic        w_accept;
  logic        w_opc_sys;
  logic [2:0]  w_f3;
  logic [11:0] w_id;
  logic [4:0]  w_zimm;
  logic [4:0]  w_rd;
  logic        w_is_ecall;
  logic        w_is_mret;
  logic        w_id_ok;
  logic        w_is_csr;
  logic        w_csr_write;
  logic        w_illegal;
  logic [2:0]  w_op;
  logic [63:0] w_operand;

  assign w_accept = in_valid && (r_state == S_IDLE);

  // Decode always works on the latched instruction so the caller may change inputs.
  assign w_opc_sys  = (r_inst[6:0] == 7'b1110011);
  assign w_f3       = r_inst[14:12];
  assign w_id       = r_inst[31:20];
  assign w_zimm     = r_inst[19:15];
  assign w_rd       = r_inst[11:7];
  assign w_is_ecall = (r_inst == 32'h0000_0073);
  assign w_is_mret  = (r_inst == 32'h3020_0073);

  always_comb begin
    w_id_ok = 1'b0;
    case (w_id)
      12'h300, 12'h304, 12'h305,
      12'h340, 12'h341, 12'h342, 12'h344: w_id_ok = 1'b1;
      default:                            w_id_ok = 1'b0;
    endcase
  end

  // funct3[1:0]==00 covers both the 000 (non ecall/mret) and 100 illegal cases.
  assign w_is_csr    = w_opc_sys && (w_f3[1:0] != 2'b00) && w_id_ok;
  assign w_illegal   = !(w_is_csr || w_is_ecall || w_is_mret);
  assign w_csr_write = w_is_csr && ((w_f3[1:0] == 2'b01) || (w_zimm != 5'd0));
  assign w_operand   = w_f3[2] ? {59'd0, w_zimm} : r_rs1;

  always_comb begin
    w_op = 3'b000;
    case (w_f3[1:0])
      2'b10:   w_op = 3'b001;
      2'b11:   w_op = 3'b010;
      default: w_op = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst        <= '0;
      r_pc          <= '0;
      r_rs1         <= '0;
      r_rd_data     <= '0;
      r_redirect_pc <= '0;
    end else begin
      if (w_accept) begin
        r_inst <= inst;
        r_pc   <= pc;
        r_rs1  <= rs1_data;
      end
      if (r_state == S_EXEC) begin
        r_rd_data <= w_is_csr ? csrres : '0;
        if (w_is_ecall) begin
          r_redirect_pc <= mtvec_o;
        end else if (w_is_mret) begin
          r_redirect_pc <= mepc_o;
        end else begin
          r_redirect_pc <= '0;
        end
      end
    end
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    Csrwen      = 1'b0;
    Ecall       = 1'b0;
    Mret        = 1'b0;
    CsrOp       = '0;
    CsrId       = '0;
    datain      = '0;
    epc_in      = '0;
    rd_wen      = 1'b0;
    rd_addr     = '0;
    rd_data     = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    illegal     = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_EXEC: begin
        Csrwen = w_csr_write;
        Ecall  = w_is_ecall;
        Mret   = w_is_mret;
        if (w_is_csr) begin
          CsrOp  = w_op;
          CsrId  = w_id;
          datain = w_operand;
        end
        if (w_is_ecall) epc_in = r_pc;
      end
      S_RESP: begin
        out_valid   = 1'b1;
        illegal     = w_illegal;
        redirect    = w_is_ecall || w_is_mret;
        redirect_pc = r_redirect_pc;
        if (w_is_csr) begin
          rd_addr = w_rd;
          rd_wen  = (w_rd != 5'd0);
          rd_data = r_rd_data;
        end
      end
      default: ;
    endcase
  end

endmodule
